// File: rtl/alu_pkg.sv
// Shared ALU control encodings and the RV32M multiply op enum, used by the
// core's ALU mux and by the iterative multiplier controller.
package alu_pkg;

  // One-hot ALU unit select
  localparam logic [3:0] ALU_SEL_ADD   = 4'b0001;
  localparam logic [3:0] ALU_SEL_BOOL  = 4'b0100;
  localparam logic [3:0] ALU_SEL_SHIFT = 4'b1000;

  // Boolean unit function select
  localparam logic [1:0] BOOL_XOR = 2'b00;
  localparam logic [1:0] BOOL_OR  = 2'b10;
  localparam logic [1:0] BOOL_AND = 2'b11;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  // MULH/MULHSU need the operand/result sign-fix steps
  function automatic logic mul_op_signed(input mul_op_e op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Request/result handshake plus the borrowed-ALU control bus of mul_seq.
// slave = multiplier side, master = execute stage / ALU side.
interface mul_seq_if #(
  parameter int XLEN = 32
);
  // request
  logic            i_valid;
  logic            o_ready;
  logic [1:0]      i_op;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic            i_flush;
  // result
  logic            o_done;
  logic [XLEN-1:0] o_result;
  // shared ALU controls
  logic            o_alu_own;
  logic [XLEN-1:0] o_alu_op_a;
  logic [XLEN-1:0] o_alu_op_b;
  logic            o_alu_sub;
  logic [1:0]      o_alu_bool_op;
  logic [3:0]      o_alu_op_sel;
  logic            o_alu_shift_dir;
  logic [XLEN-1:0] i_alu_result;

  modport slave (
    input  i_valid, i_op, i_rs1, i_rs2, i_flush, i_alu_result,
    output o_ready, o_done, o_result,
    output o_alu_own, o_alu_op_a, o_alu_op_b, o_alu_sub,
    output o_alu_bool_op, o_alu_op_sel, o_alu_shift_dir
  );

  modport master (
    output i_valid, i_op, i_rs1, i_rs2, i_flush, i_alu_result,
    input  o_ready, o_done, o_result,
    input  o_alu_own, o_alu_op_a, o_alu_op_b, o_alu_sub,
    input  o_alu_bool_op, o_alu_op_sel, o_alu_shift_dir
  );
endinterface

// File: rtl/mul_seq.sv
// Iterative shift-add 32x32 multiplier using the core's shared ALU for its adds.
// Optional macro MUL_SIGNED_EN compiles the sign-fix states for MULH/MULHSU.
module mul_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     i_clk,
  input  logic     i_rst,
  mul_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
`ifdef MUL_SIGNED_EN
    S_FIXA  = 3'd1,
    S_FIXB  = 3'd2,
`endif
    S_ITER  = 3'd3,
`ifdef MUL_SIGNED_EN
    S_FIXLO = 3'd4,
    S_FIXHI = 3'd5,
`endif
    S_DONE  = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [4:0]      cnt_q, cnt_d;
  mul_op_e         op_q, op_d;
`ifdef MUL_SIGNED_EN
  logic            neg_q, neg_d;
  logic            sgn_q, sgn_d;
  logic            lo_zero_q, lo_zero_d;
`endif

  logic            ready, done;
  logic [XLEN-1:0] result;
  logic            alu_own, alu_sub;
  logic [XLEN-1:0] alu_a, alu_b;
  logic [1:0]      alu_bool;
  logic [3:0]      alu_sel;
  logic            carry;

  // Carry out of hi + mcand, recovered from the 32-bit ALU sum's MSB
  assign carry = (hi_q[XLEN-1] & mcand_q[XLEN-1]) |
                 ((hi_q[XLEN-1] | mcand_q[XLEN-1]) & ~bus.i_alu_result[XLEN-1]);

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
`ifdef MUL_SIGNED_EN
    neg_d     = neg_q;
    sgn_d     = sgn_q;
    lo_zero_d = lo_zero_q;
`endif
    ready     = 1'b0;
    done      = 1'b0;
    result    = '0;
    alu_own   = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_sub   = 1'b0;
    alu_bool  = BOOL_XOR;
    alu_sel   = '0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.i_valid && !bus.i_flush) begin
          lo_d    = bus.i_rs1;
          mcand_d = bus.i_rs2;
          hi_d    = '0;
          cnt_d   = '0;
          op_d    = mul_op_e'(bus.i_op);
`ifdef MUL_SIGNED_EN
          sgn_d     = mul_op_signed(mul_op_e'(bus.i_op));
          lo_zero_d = 1'b0;
          case (mul_op_e'(bus.i_op))
            MUL_OP_MULH:   neg_d = bus.i_rs1[XLEN-1] ^ bus.i_rs2[XLEN-1];
            MUL_OP_MULHSU: neg_d = bus.i_rs1[XLEN-1];
            default:       neg_d = 1'b0;
          endcase
          state_d = sgn_d ? S_FIXA : S_ITER;
`else
          state_d = S_ITER;
`endif
        end
      end

`ifdef MUL_SIGNED_EN
      S_FIXA: begin
        alu_own = 1'b1;
        alu_b   = lo_q;
        alu_sub = 1'b1;
        alu_sel = ALU_SEL_ADD;
        if (lo_q[XLEN-1]) lo_d = bus.i_alu_result;
        state_d = S_FIXB;
      end

      S_FIXB: begin
        alu_own = 1'b1;
        alu_b   = mcand_q;
        alu_sub = 1'b1;
        alu_sel = ALU_SEL_ADD;
        if (op_q == MUL_OP_MULH && mcand_q[XLEN-1]) mcand_d = bus.i_alu_result;
        state_d = S_ITER;
      end
`endif

      S_ITER: begin
        alu_own = 1'b1;
        alu_a   = hi_q;
        alu_b   = mcand_q;
        alu_sel = ALU_SEL_ADD;
        // {hi,lo} shifts right one bit per step, folding in the add when lo[0]
        if (lo_q[0]) begin
          hi_d = {carry, bus.i_alu_result[XLEN-1:1]};
          lo_d = {bus.i_alu_result[0], lo_q[XLEN-1:1]};
        end else begin
          hi_d = {1'b0, hi_q[XLEN-1:1]};
          lo_d = {hi_q[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
`ifdef MUL_SIGNED_EN
          state_d = sgn_q ? S_FIXLO : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end

`ifdef MUL_SIGNED_EN
      S_FIXLO: begin
        alu_own   = 1'b1;
        alu_b     = lo_q;
        alu_sub   = 1'b1;
        alu_sel   = ALU_SEL_ADD;
        lo_zero_d = (lo_q == '0);
        if (neg_q) lo_d = bus.i_alu_result;
        state_d = S_FIXHI;
      end

      // 64-bit negate: hi becomes ~hi, plus one only when lo borrowed nothing
      S_FIXHI: begin
        alu_own = 1'b1;
        if (lo_zero_q) begin
          alu_b   = hi_q;
          alu_sub = 1'b1;
          alu_sel = ALU_SEL_ADD;
        end else begin
          alu_a    = hi_q;
          alu_b    = '1;
          alu_bool = BOOL_XOR;
          alu_sel  = ALU_SEL_BOOL;
        end
        if (neg_q) hi_d = bus.i_alu_result;
        state_d = S_DONE;
      end
`endif

      S_DONE: begin
        done    = 1'b1;
        result  = (op_q == MUL_OP_MUL) ? lo_q : hi_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (bus.i_flush && state_q != S_IDLE && state_q != S_DONE) state_d = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      op_q      <= MUL_OP_MUL;
`ifdef MUL_SIGNED_EN
      neg_q     <= 1'b0;
      sgn_q     <= 1'b0;
      lo_zero_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
`ifdef MUL_SIGNED_EN
      neg_q     <= neg_d;
      sgn_q     <= sgn_d;
      lo_zero_q <= lo_zero_d;
`endif
    end
  end

  assign bus.o_ready         = ready;
  assign bus.o_done          = done;
  assign bus.o_result        = result;
  assign bus.o_alu_own       = alu_own;
  assign bus.o_alu_op_a      = alu_a;
  assign bus.o_alu_op_b      = alu_b;
  assign bus.o_alu_sub       = alu_sub;
  assign bus.o_alu_bool_op   = alu_own ? alu_bool : 2'b00;
  assign bus.o_alu_op_sel    = alu_sel;
  assign bus.o_alu_shift_dir = 1'b0;

endmodule

// File: tb/tb_mul_seq.sv
// Randomized self-checking bench for mul_seq: models the shared ALU and
// checks results against 64-bit arithmetic products (either MUL_SIGNED_EN build).
module tb_mul_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mul_seq_if bus ();

  mul_seq dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Behavioural stand-in for the core's combinational ALU
  logic [31:0] alu_r;
  always_comb begin
    alu_r = '0;
    case (bus.o_alu_op_sel)
      ALU_SEL_ADD: alu_r = bus.o_alu_sub ? bus.o_alu_op_a - bus.o_alu_op_b
                                         : bus.o_alu_op_a + bus.o_alu_op_b;
      ALU_SEL_BOOL: begin
        case (bus.o_alu_bool_op)
          BOOL_XOR: alu_r = bus.o_alu_op_a ^ bus.o_alu_op_b;
          BOOL_OR:  alu_r = bus.o_alu_op_a | bus.o_alu_op_b;
          BOOL_AND: alu_r = bus.o_alu_op_a & bus.o_alu_op_b;
          default:  alu_r = '0;
        endcase
      end
      ALU_SEL_SHIFT: alu_r = bus.o_alu_shift_dir ? bus.o_alu_op_a >> bus.o_alu_op_b[4:0]
                                                 : bus.o_alu_op_a << bus.o_alu_op_b[4:0];
      default: alu_r = '0;
    endcase
  end
  assign bus.i_alu_result = alu_r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_sgn(input logic [1:0] op);
`ifdef MUL_SIGNED_EN
    return (op == 2'b01) || (op == 2'b10);
`else
    return 1'b0;
`endif
  endfunction

  // Reference: full 64-bit product of sign/zero-extended operands
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {32'b0, a};
    eb = {32'b0, b};
    if (is_sgn(op)) ea = {{32{a[31]}}, a};
    if (is_sgn(op) && op == 2'b01) eb = {{32{b[31]}}, b};
    p = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic alu_nonzero();
    return (bus.o_alu_op_a != 0) || (bus.o_alu_op_b != 0) || bus.o_alu_sub ||
           (bus.o_alu_bool_op != 0) || (bus.o_alu_op_sel != 0) || bus.o_alu_shift_dir;
  endfunction

  // flush_k > 0: flush at T+flush_k; flush_k < 0: flush during the DONE cycle
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int flush_k, input string tag);
    int lat, done_cnt, done_k, own_bad, alu_bad, res_bad;
    logic own_exp, hold;
    logic [31:0] exp;
    lat      = is_sgn(op) ? 37 : 33;
    exp      = ref_mul(op, a, b);
    hold     = (flush_k == 0) && ($urandom_range(0, 1) == 1);
    done_cnt = 0; done_k = 0; own_bad = 0; alu_bad = 0; res_bad = 0;
    chk({tag, ":ready_idle"}, 32'(bus.o_ready), 32'd1);
    bus.i_valid = 1'b1; bus.i_op = op; bus.i_rs1 = a; bus.i_rs2 = b;
    for (int k = 1; k <= lat + 2; k++) begin
      @(posedge clk); #1;
      bus.i_flush = 1'b0;
      if (!hold) bus.i_valid = 1'b0;
      else begin
        bus.i_op = 2'($urandom); bus.i_rs1 = $urandom; bus.i_rs2 = $urandom;
      end
      own_exp = (flush_k > 0) ? (k <= flush_k) : (k < lat);
      if (bus.o_alu_own !== own_exp) own_bad++;
      if (!bus.o_alu_own && alu_nonzero()) alu_bad++;
      if (bus.o_done) begin
        done_cnt++; done_k = k;
        if (k == lat) chk({tag, ":result"}, bus.o_result, exp);
      end else if (bus.o_result != 0) res_bad++;
      if (k == lat) bus.i_valid = 1'b0;
      if (flush_k > 0 && k == flush_k + 1) chk({tag, ":ready_after_flush"}, 32'(bus.o_ready), 32'd1);
      if (flush_k <= 0 && k == lat + 1) chk({tag, ":ready_after_done"}, 32'(bus.o_ready), 32'd1);
      if (k == flush_k || (flush_k < 0 && k == lat)) bus.i_flush = 1'b1;
    end
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    chk({tag, ":own_window"}, 32'(own_bad), 32'd0);
    chk({tag, ":alu_idle_zero"}, 32'(alu_bad), 32'd0);
    chk({tag, ":result_idle_zero"}, 32'(res_bad), 32'd0);
    chk({tag, ":done_count"}, 32'(done_cnt), (flush_k > 0) ? 32'd0 : 32'd1);
    chk({tag, ":done_cycle"}, 32'(done_k), (flush_k > 0) ? 32'd0 : 32'(lat));
  endtask

  initial begin
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_op = 2'b00; bus.i_rs1 = '0; bus.i_rs2 = '0; bus.i_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset:ready", 32'(bus.o_ready), 32'd1);
    chk("reset:done", 32'(bus.o_done), 32'd0);
    chk("reset:result", bus.o_result, 32'd0);
    chk("reset:own", 32'(bus.o_alu_own), 32'd0);
    chk("reset:alu", 32'(alu_nonzero()), 32'd0);

    do_op(2'b00, 32'd6, 32'd7, 0, "mul_6x7");
    do_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulhu_ff");
    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mul_ff");
    do_op(2'b01, 32'hFFFFFFFF, 32'd2, 0, "mulh_m1x2");
    do_op(2'b01, 32'h80000000, 32'h80000000, 0, "mulh_min");
    do_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulhsu_ff");
    do_op(2'b01, 32'h00000003, 32'hFFFFFFFB, 0, "mulh_3xm5");
    do_op(2'b00, 32'h12345678, 32'h0000ABCD, 10, "mul_flush");
    do_op(2'b00, 32'd3, 32'd5, 0, "mul_3x5");
    do_op(2'b01, 32'h80000001, 32'h7FFFFFFF, 1, "mulh_flush_early");
    do_op(2'b11, 32'hDEADBEEF, 32'h12345678, -1, "mulhu_flush_done");

    // flush held with valid in IDLE blocks acceptance
    bus.i_valid = 1'b1; bus.i_flush = 1'b1; bus.i_op = 2'b00; bus.i_rs1 = 32'd9; bus.i_rs2 = 32'd9;
    @(posedge clk); #1;
    bus.i_valid = 1'b0; bus.i_flush = 1'b0;
    chk("idle_flush:ready", 32'(bus.o_ready), 32'd1);
    chk("idle_flush:own", 32'(bus.o_alu_own), 32'd0);

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: b = 32'hFFFFFFFF;
        2: a = 32'd0;
        default: ;
      endcase
      do_op(op, a, b, 0, "rand");
    end

    // reset mid-operation discards the op
    bus.i_valid = 1'b1; bus.i_op = 2'b00; bus.i_rs1 = 32'd11; bus.i_rs2 = 32'd13;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset:ready", 32'(bus.o_ready), 32'd1);
    chk("midreset:own", 32'(bus.o_alu_own), 32'd0);
    chk("midreset:result", bus.o_result, 32'd0);
    begin
      int late_done = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (bus.o_done) late_done++;
      end
      chk("midreset:no_done", 32'(late_done), 32'd0);
    end

    do_op(2'b00, 32'd3, 32'd5, 0, "mul_after_reset");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
